pc_sequencer: RTL and testbench

Multicycle next-PC unit that consumes the jump/branch fields decoded from an instruction and produces the architectural PC. It forms jump targets as {PC[31:26], Immediate26} and branch targets as PC plus the sign-extended 16-bit offset. It adds a small return-address stack for CALL/RET. It sits between the control FSM (requester) and instruction fetch (PC consumer).

---
 rtl/pc_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_pc_sequencer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: multicycle next-PC unit with a small return-address stack.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | ready for a request; operands and current PC latched on accept
// ST_CALC   | next_pc formed, return-address stack pushed or popped
// ST_COMMIT | PC takes next_pc, pc_valid pulses, back to ST_IDLE
module pc_sequencer #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          RAS_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_op,
   input  logic        BranchTaken,
   input  logic [15:0] Immediate16,
   input  logic [25:0] Immediate26,
   input  logic [31:0] RegTarget,
   output logic [31:0] PC,
   output logic        pc_valid,
   output logic        ras_overflow,
   output logic        ras_underflow
);

   localparam int PTR_W = $clog2(RAS_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [2:0] OP_SEQ  = 3'b000;
   localparam logic [2:0] OP_BR   = 3'b001;
   localparam logic [2:0] OP_J    = 3'b010;
   localparam logic [2:0] OP_CALL = 3'b011;
   localparam logic [2:0] OP_JR   = 3'b100;
   localparam logic [2:0] OP_RET  = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CALC   = 2'd1,
      ST_COMMIT = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [31:0]        pc_q, pc_d;
   logic               req_ready_q, req_ready_d;
   logic               pc_valid_q, pc_valid_d;
   logic               ovf_q, ovf_d;
   logic               udf_q, udf_d;
   logic [2:0]         op_q, op_d;
   logic               bt_q, bt_d;
   logic [15:0]        imm16_q, imm16_d;
   logic [25:0]        imm26_q, imm26_d;
   logic [31:0]        rt_q, rt_d;
   logic [31:0]        base_pc_q, base_pc_d;
   logic [31:0]        next_pc_q, next_pc_d;
   logic [PTR_W-1:0]   top_q, top_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [31:0]        ras_q [RAS_DEPTH];
   logic [31:0]        ras_d [RAS_DEPTH];

   logic [31:0]        seq_pc;
   logic [31:0]        br_pc;
   logic [31:0]        jmp_pc;
   logic [PTR_W-1:0]   push_idx;

   assign seq_pc   = base_pc_q + 32'd1;
   assign br_pc    = base_pc_q + {{16{imm16_q[15]}}, imm16_q};
   // Jump upper bits come from the accepted PC itself, not PC+1.
   assign jmp_pc   = {base_pc_q[31:26], imm26_q};
   // When the stack is full this slot is the oldest entry, so it is overwritten.
   assign push_idx = top_q + PTR_W'(1);

   // Next-state and datapath update for the sequencing FSM.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      req_ready_d = req_ready_q;
      pc_valid_d  = 1'b0;
      ovf_d       = ovf_q;
      udf_d       = udf_q;
      op_d        = op_q;
      bt_d        = bt_q;
      imm16_d     = imm16_q;
      imm26_d     = imm26_q;
      rt_d        = rt_q;
      base_pc_d   = base_pc_q;
      next_pc_d   = next_pc_q;
      top_d       = top_q;
      cnt_d       = cnt_q;
      ras_d       = ras_q;

      case (state_q)
         ST_IDLE: begin
            req_ready_d = 1'b1;
            if (req_valid) begin
               op_d        = req_op;
               bt_d        = BranchTaken;
               imm16_d     = Immediate16;
               imm26_d     = Immediate26;
               rt_d        = RegTarget;
               base_pc_d   = pc_q;
               req_ready_d = 1'b0;
               state_d     = ST_CALC;
            end
         end
         ST_CALC: begin
            req_ready_d = 1'b0;
            state_d     = ST_COMMIT;
            case (op_q)
               OP_SEQ:  next_pc_d = seq_pc;
               OP_BR:   next_pc_d = bt_q ? br_pc : seq_pc;
               OP_J:    next_pc_d = jmp_pc;
               OP_CALL: begin
                  next_pc_d       = jmp_pc;
                  ras_d[push_idx] = seq_pc;
                  top_d           = push_idx;
                  if (cnt_q == CNT_W'(RAS_DEPTH)) begin
                     ovf_d = 1'b1;
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
               OP_JR:   next_pc_d = rt_q;
               OP_RET: begin
                  if (cnt_q == '0) begin
                     next_pc_d = rt_q;
                     udf_d     = 1'b1;
                  end else begin
                     next_pc_d = ras_q[top_q];
                     top_d     = top_q - PTR_W'(1);
                     cnt_d     = cnt_q - CNT_W'(1);
                  end
               end
               default: next_pc_d = base_pc_q;
            endcase
         end
         ST_COMMIT: begin
            pc_d        = next_pc_q;
            pc_valid_d  = 1'b1;
            req_ready_d = 1'b1;
            state_d     = ST_IDLE;
         end
         default: begin
            req_ready_d = 1'b1;
            state_d     = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset abandons any request in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         pc_q        <= RESET_PC;
         req_ready_q <= 1'b1;
         pc_valid_q  <= 1'b0;
         ovf_q       <= 1'b0;
         udf_q       <= 1'b0;
         op_q        <= OP_SEQ;
         bt_q        <= 1'b0;
         imm16_q     <= '0;
         imm26_q     <= '0;
         rt_q        <= '0;
         base_pc_q   <= RESET_PC;
         next_pc_q   <= RESET_PC;
         top_q       <= '0;
         cnt_q       <= '0;
         for (int i = 0; i < RAS_DEPTH; i++) begin
            ras_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         req_ready_q <= req_ready_d;
         pc_valid_q  <= pc_valid_d;
         ovf_q       <= ovf_d;
         udf_q       <= udf_d;
         op_q        <= op_d;
         bt_q        <= bt_d;
         imm16_q     <= imm16_d;
         imm26_q     <= imm26_d;
         rt_q        <= rt_d;
         base_pc_q   <= base_pc_d;
         next_pc_q   <= next_pc_d;
         top_q       <= top_d;
         cnt_q       <= cnt_d;
         ras_q       <= ras_d;
      end
   end

   assign req_ready     = req_ready_q;
   assign PC            = pc_q;
   assign pc_valid      = pc_valid_q;
   assign ras_overflow  = ovf_q;
   assign ras_underflow = udf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench for pc_sequencer with a queue-based reference model.
module tb_pc_sequencer;

   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam int          RAS_DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [2:0]  req_op = '0;
   logic        BranchTaken = 1'b0;
   logic [15:0] Immediate16 = '0;
   logic [25:0] Immediate26 = '0;
   logic [31:0] RegTarget = '0;
   logic [31:0] PC;
   logic        pc_valid;
   logic        ras_overflow;
   logic        ras_underflow;

   pc_sequencer #(.RESET_PC(RESET_PC), .RAS_DEPTH(RAS_DEPTH)) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_op       (req_op),
      .BranchTaken  (BranchTaken),
      .Immediate16  (Immediate16),
      .Immediate26  (Immediate26),
      .RegTarget    (RegTarget),
      .PC           (PC),
      .pc_valid     (pc_valid),
      .ras_overflow (ras_overflow),
      .ras_underflow(ras_underflow)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] pc;
      logic        ovf;
      logic        udf;
      int unsigned acc;
   } exp_t;

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_fail = 0;

   // reference model state: newest return address at the back of m_ras
   logic [31:0] m_pc;
   logic [31:0] m_ras[$];
   logic        m_ovf;
   logic        m_udf;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_pc = RESET_PC;
      m_ras.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
   endtask

   task automatic model_apply(input logic [2:0] op, input logic bt, input logic [15:0] i16,
                              input logic [25:0] i26, input logic [31:0] rt);
      exp_t e;
      logic [31:0] nxt;
      case (op)
         3'd0: nxt = m_pc + 1;
         3'd1: nxt = bt ? m_pc + 32'($signed(i16)) : m_pc + 1;
         3'd2: nxt = (m_pc & 32'hFC00_0000) | {6'd0, i26};
         3'd3: begin
            nxt = (m_pc & 32'hFC00_0000) | {6'd0, i26};
            if (m_ras.size() == RAS_DEPTH) begin
               void'(m_ras.pop_front());
               m_ovf = 1'b1;
            end
            m_ras.push_back(m_pc + 1);
         end
         3'd4: nxt = rt;
         3'd5: begin
            if (m_ras.size() == 0) begin
               nxt   = rt;
               m_udf = 1'b1;
            end else begin
               nxt = m_ras.pop_back();
            end
         end
         default: nxt = m_pc;
      endcase
      m_pc  = nxt;
      e.pc  = nxt;
      e.ovf = m_ovf;
      e.udf = m_udf;
      e.acc = cyc;
      sb.push_back(e);
   endtask

   task automatic scramble_inputs();
      req_op      = 3'($urandom_range(0, 7));
      BranchTaken = 1'($urandom_range(0, 1));
      Immediate16 = 16'($urandom);
      Immediate26 = 26'($urandom);
      RegTarget   = $urandom;
   endtask

   task automatic wait_ready();
      int w = 0;
      @(negedge clk);
      while (!req_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      if (!req_ready) check("ready_timeout", 32'(req_ready), 32'd1);
   endtask

   // Issue one request; inputs change to garbage while the unit is busy.
   task automatic do_req(input logic [2:0] op, input logic bt, input logic [15:0] i16,
                         input logic [25:0] i26, input logic [31:0] rt);
      wait_ready();
      req_op      = op;
      BranchTaken = bt;
      Immediate16 = i16;
      Immediate26 = i26;
      RegTarget   = rt;
      req_valid   = 1'b1;
      model_apply(op, bt, i16, i26, rt);
      @(posedge clk);
      @(negedge clk);
      scramble_inputs();
      req_valid = 1'b1;
      @(negedge clk);
      scramble_inputs();
      req_valid = 1'b0;
   endtask

   task automatic check_reset_state();
      check("rst_pc", PC, RESET_PC);
      check("rst_ready", 32'(req_ready), 32'd1);
      check("rst_pc_valid", 32'(pc_valid), 32'd0);
      check("rst_ovf", 32'(ras_overflow), 32'd0);
      check("rst_udf", 32'(ras_underflow), 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset     = 1'b1;
      req_valid = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      model_reset();
      #1;
      check_reset_state();
   endtask

   task automatic drain();
      int w = 0;
      while (sb.size() != 0 && w < 50) begin
         @(negedge clk);
         w++;
      end
      check("drain", 32'(sb.size()), 32'd0);
   endtask

   // Monitor: pops the scoreboard on every pc_valid and tracks busy-window length.
   initial begin
      int run = 0;
      exp_t e;
      forever begin
         @(negedge clk);
         #1;
         if (reset) begin
            run = 0;
         end else begin
            if (pc_valid) begin
               if (sb.size() == 0) begin
                  check("spurious_pc_valid", 32'd1, 32'd0);
               end else begin
                  e = sb.pop_front();
                  check("pc", PC, e.pc);
                  check("ovf", 32'(ras_overflow), 32'(e.ovf));
                  check("udf", 32'(ras_underflow), 32'(e.udf));
                  check("latency", cyc - e.acc, 32'd3);
               end
            end
            if (!req_ready) begin
               run++;
            end else begin
               if (run != 0) check("busy_cycles", 32'(run), 32'd2);
               run = 0;
            end
         end
      end
   end

   initial begin
      model_reset();
      do_reset();

      // sequential steps from reset
      repeat (3) do_req(3'd0, 1'b0, 16'h0, 26'h0, 32'h0);

      // jumps keep the upper PC bits of the accepted PC
      do_req(3'd4, 1'b0, 16'h0, 26'h0, 32'hAABB_CCDD);
      do_req(3'd2, 1'b0, 16'h0, 26'h123456, 32'h0);
      do_req(3'd4, 1'b0, 16'h0, 26'h0, 32'hAABB_CCDD);
      do_req(3'd2, 1'b0, 16'h0, 26'h2BCDEF, 32'h0);

      // backward branch taken, then not taken
      do_req(3'd4, 1'b0, 16'h0, 26'h0, 32'h0000_0100);
      do_req(3'd1, 1'b1, 16'hFFF0, 26'h0, 32'h0);
      do_req(3'd1, 1'b0, 16'hFFF0, 26'h0, 32'h0);

      // PC wrap
      do_req(3'd4, 1'b0, 16'h0, 26'h0, 32'hFFFF_FFFF);
      do_req(3'd0, 1'b0, 16'h0, 26'h0, 32'h0);
      drain();

      // simple call/return, flags must stay clear
      do_reset();
      do_req(3'd4, 1'b0, 16'h0, 26'h0, 32'h0000_0010);
      do_req(3'd3, 1'b0, 16'h0, 26'h200, 32'h0);
      do_req(3'd5, 1'b0, 16'h0, 26'h0, 32'h0000_DEAD);

      // five nested calls overflow the stack; fifth return underflows
      for (int i = 0; i < 5; i++) do_req(3'd3, 1'b0, 16'h0, 26'h300 + 26'(i * 16), 32'h0);
      for (int i = 0; i < 5; i++) do_req(3'd5, 1'b0, 16'h0, 26'h0, 32'h0000_DEAD);
      drain();

      // reset in the middle of a CALL; nothing must commit
      do_req(3'd4, 1'b0, 16'h0, 26'h0, 32'h0000_0040);
      drain();
      wait_ready();
      req_op      = 3'd3;
      Immediate26 = 26'h777;
      req_valid   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset     = 1'b1;
      req_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      #1;
      check_reset_state();
      repeat (4) @(negedge clk);
      do_req(3'd5, 1'b0, 16'h0, 26'h0, 32'h0000_DEAD);
      drain();

      // randomized traffic
      do_reset();
      for (int i = 0; i < 200; i++) begin
         do_req(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 16'($urandom),
                26'($urandom), $urandom);
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
